// File: rtl/cluster_serializer.sv
// cluster_serializer: captures 8-cluster frames and presents pending clusters one per cycle, slot 0 first
// Ports: clock4x/reset_n (async active-low) clock and reset; clusters_valid with adr0..7/cnt0..7 is the frame strobe;
// out_valid/out_ready handshake the presented out_adr/out_cnt with out_sof/out_eof frame markers;
// busy flags SEND; overflow_cnt counts frames overwritten before full delivery (saturating).
module cluster_serializer #(
  parameter int NSTRIPS = 1536,
  parameter int OVF_W = 8
) (
  input  logic clock4x,
  input  logic reset_n,
  input  logic clusters_valid,
  input  logic [10:0] adr0,
  input  logic [10:0] adr1,
  input  logic [10:0] adr2,
  input  logic [10:0] adr3,
  input  logic [10:0] adr4,
  input  logic [10:0] adr5,
  input  logic [10:0] adr6,
  input  logic [10:0] adr7,
  input  logic [2:0] cnt0,
  input  logic [2:0] cnt1,
  input  logic [2:0] cnt2,
  input  logic [2:0] cnt3,
  input  logic [2:0] cnt4,
  input  logic [2:0] cnt5,
  input  logic [2:0] cnt6,
  input  logic [2:0] cnt7,
  input  logic out_ready,
  output logic out_valid,
  output logic [10:0] out_adr,
  output logic [2:0] out_cnt,
  output logic out_sof,
  output logic out_eof,
  output logic busy,
  output logic [OVF_W-1:0] overflow_cnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [11:0] NS = 12'(NSTRIPS);
  logic [10:0] adr_in [8];
  logic [2:0] cnt_in [8];
  logic [10:0] adr_q [8];
  logic [2:0] cnt_q [8];
  logic [7:0] pending, new_mask;
  logic [2:0] sel;
  logic [0:0] state;
  logic sof_q, last, hs, ovf_inc;
  assign adr_in = '{adr0, adr1, adr2, adr3, adr4, adr5, adr6, adr7};
  assign cnt_in = '{cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7};
  always_comb begin
    new_mask = '0;
    for (int i = 0; i < 8; i++) new_mask[i] = {1'b0, adr_in[i]} < NS;
  end
  always_comb begin
    sel = '0;
    for (int i = 7; i >= 0; i--) if (pending[i]) sel = 3'(i);
  end
  // outputs depend only on registered state, so they clear the instant reset asserts
  assign out_valid = |pending;
  assign last = out_valid && ((pending & (pending - 8'd1)) == 8'd0);
  assign out_adr = out_valid ? adr_q[sel] : '0;
  assign out_cnt = out_valid ? cnt_q[sel] : '0;
  assign out_sof = out_valid & sof_q;
  assign out_eof = last;
  assign busy = state == SEND;
  assign hs = out_valid & out_ready;
  // an empty frame drops nothing worth counting; finishing the old frame on the capture edge is not a loss
  assign ovf_inc = clusters_valid && |new_mask && out_valid && !(hs && last);
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pending <= '0;
      sof_q <= 1'b0;
      overflow_cnt <= '0;
      for (int i = 0; i < 8; i++) begin
        adr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      if (clusters_valid) begin
        adr_q <= adr_in;
        cnt_q <= cnt_in;
        pending <= new_mask;
        sof_q <= |new_mask;
        state <= |new_mask ? SEND : IDLE;
      end else if (hs) begin
        pending[sel] <= 1'b0;
        sof_q <= 1'b0;
        state <= last ? IDLE : SEND;
      end
      if (ovf_inc && overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cluster_serializer.sv
// tb_cluster_serializer: directed checks of cluster_serializer capture, delivery, overflow and reset
module tb_cluster_serializer;
  logic clock4x = 1'b0;
  logic reset_n, clusters_valid, out_ready;
  logic [10:0] fa [8];
  logic [2:0] fc [8];
  logic out_valid, out_sof, out_eof, busy;
  logic [10:0] out_adr;
  logic [2:0] out_cnt;
  logic [7:0] overflow_cnt;
  int total = 0;
  int passed = 0;
  always #5 clock4x = ~clock4x;
  cluster_serializer dut (
    .clock4x(clock4x), .reset_n(reset_n), .clusters_valid(clusters_valid),
    .adr0(fa[0]), .adr1(fa[1]), .adr2(fa[2]), .adr3(fa[3]),
    .adr4(fa[4]), .adr5(fa[5]), .adr6(fa[6]), .adr7(fa[7]),
    .cnt0(fc[0]), .cnt1(fc[1]), .cnt2(fc[2]), .cnt3(fc[3]),
    .cnt4(fc[4]), .cnt5(fc[5]), .cnt6(fc[6]), .cnt7(fc[7]),
    .out_ready(out_ready), .out_valid(out_valid), .out_adr(out_adr), .out_cnt(out_cnt),
    .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .overflow_cnt(overflow_cnt)
  );
  task automatic tick();
    @(posedge clock4x);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic present(input string tag, input int v, input int a, input int c, input int s, input int e);
    check({tag, " valid"}, 32'(out_valid), 32'(v));
    check({tag, " adr"}, 32'(out_adr), 32'(a));
    check({tag, " cnt"}, 32'(out_cnt), 32'(c));
    check({tag, " sof"}, 32'(out_sof), 32'(s));
    check({tag, " eof"}, 32'(out_eof), 32'(e));
  endtask
  initial begin
    reset_n = 1'b0;
    clusters_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fa[i] = 11'(i + 1);
      fc[i] = 3'(i);
    end
    tick();
    tick();
    present("reset", 0, 0, 0, 0, 0);
    check("reset busy", 32'(busy), 0);
    check("reset ovf", 32'(overflow_cnt), 0);
    clusters_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    present("post reset idle", 0, 0, 0, 0, 0);
    // two valid slots among invalid ones
    fa = '{11'd5, 11'd2047, 11'd100, 11'd2047, 11'd2047, 11'd2047, 11'd2047, 11'd2047};
    fc = '{3'd1, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    clusters_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    clusters_valid = 1'b0;
    present("sparse first", 1, 5, 1, 1, 0);
    check("sparse busy", 32'(busy), 1);
    tick();
    present("sparse second", 1, 100, 3, 0, 1);
    tick();
    present("sparse done", 0, 0, 0, 0, 0);
    check("sparse idle busy", 32'(busy), 0);
    // backpressure then full drain
    for (int i = 0; i < 8; i++) begin
      fa[i] = 11'(10 * (i + 1));
      fc[i] = 3'(i);
    end
    out_ready = 1'b0;
    clusters_valid = 1'b1;
    tick();
    clusters_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      present("stall hold", 1, 10, 0, 1, 0);
      if (i < 9) tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      present("drain", 1, 10 * (k + 1), k, k == 0 ? 1 : 0, k == 7 ? 1 : 0);
      tick();
    end
    present("drain done", 0, 0, 0, 0, 0);
    check("drain ovf", 32'(overflow_cnt), 0);
    // overwrite a partly delivered frame
    for (int i = 0; i < 8; i++) begin
      fa[i] = 11'(100 + i);
      fc[i] = 3'(7 - i);
    end
    clusters_valid = 1'b1;
    tick();
    clusters_valid = 1'b0;
    tick();
    tick();
    tick();
    present("partial", 1, 103, 4, 0, 0);
    for (int i = 0; i < 8; i++) begin
      fa[i] = 11'(200 + i);
      fc[i] = 3'(i);
    end
    out_ready = 1'b0;
    clusters_valid = 1'b1;
    tick();
    clusters_valid = 1'b0;
    check("overwrite ovf", 32'(overflow_cnt), 1);
    present("overwrite new", 1, 200, 0, 1, 0);
    // capture on the same edge as the last handshake
    out_ready = 1'b1;
    repeat (7) tick();
    present("last slot", 1, 207, 7, 0, 1);
    fa = '{11'd300, 11'd2047, 11'd2047, 11'd2047, 11'd2047, 11'd2047, 11'd2047, 11'd2047};
    fc = '{3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    clusters_valid = 1'b1;
    tick();
    clusters_valid = 1'b0;
    out_ready = 1'b0;
    check("same edge ovf", 32'(overflow_cnt), 1);
    present("same edge new", 1, 300, 6, 1, 1);
    out_ready = 1'b1;
    tick();
    present("same edge done", 0, 0, 0, 0, 0);
    // saturation
    for (int i = 0; i < 8; i++) begin
      fa[i] = 11'(i + 1);
      fc[i] = 3'(i);
    end
    out_ready = 1'b0;
    clusters_valid = 1'b1;
    repeat (300) tick();
    check("saturate ovf", 32'(overflow_cnt), 255);
    for (int i = 0; i < 8; i++) fa[i] = 11'd2047;
    tick();
    clusters_valid = 1'b0;
    present("all invalid", 0, 0, 0, 0, 0);
    check("all invalid busy", 32'(busy), 0);
    check("all invalid ovf", 32'(overflow_cnt), 255);
    tick();
    check("ovf held", 32'(overflow_cnt), 255);
    // asynchronous reset mid-delivery
    for (int i = 0; i < 8; i++) begin
      fa[i] = 11'(i + 1);
      fc[i] = 3'(i);
    end
    out_ready = 1'b1;
    clusters_valid = 1'b1;
    tick();
    clusters_valid = 1'b0;
    tick();
    present("pre reset", 1, 2, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    present("async reset", 0, 0, 0, 0, 0);
    check("async reset busy", 32'(busy), 0);
    check("async reset ovf", 32'(overflow_cnt), 0);
    tick();
    reset_n = 1'b1;
    tick();
    present("after release", 0, 0, 0, 0, 0);
    fa[0] = 11'd42;
    fc[0] = 3'd5;
    out_ready = 1'b0;
    clusters_valid = 1'b1;
    tick();
    clusters_valid = 1'b0;
    present("recapture", 1, 42, 5, 1, 0);
    check("recapture ovf", 32'(overflow_cnt), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cluster_serializer.md
CLUSTER_SERIALIZER -- requirements
Module: cluster_serializer

Interface
REQ-001 Parameter NSTRIPS, default 1536: a cluster is valid iff its adr < NSTRIPS.
REQ-002 Parameter OVF_W, default 8: width of overflow_cnt.
REQ-003 clock4x  in  1  sole clock (160 MHz frame-rate logic clock); all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 clusters_valid  in  1  strobe: adr0..adr7/cnt0..cnt7 hold a new 8-cluster frame this cycle.
REQ-006 adr0..adr7  in  11 each  cluster addresses from the encoder mux; slot 0 is highest priority.
REQ-007 cnt0..cnt7  in  3 each  cluster sizes paired with adrN.
REQ-008 out_ready  in  1  downstream accepts the presented cluster.
REQ-009 out_valid  out  1  out_adr/out_cnt hold a valid cluster.
REQ-010 out_adr  out  11  presented cluster address.
REQ-011 out_cnt  out  3  presented cluster size.
REQ-012 out_sof  out  1  presented cluster is the first delivered cluster of its frame.
REQ-013 out_eof  out  1  presented cluster is the last pending cluster of its frame.
REQ-014 busy  out  1  FSM in SEND.
REQ-015 overflow_cnt  out  OVF_W  saturating count of frames overwritten before full delivery.

Function
REQ-016 Capture: at a rising edge with clusters_valid=1, all 8 {cnt,adr} pairs are registered into slot buffer; pending[i] = (adrI < NSTRIPS).
REQ-017 FSM states IDLE (pending==0) and SEND (pending!=0); IDLE->SEND on capture with nonzero valid mask; SEND->IDLE when last pending bit is handshaken and no capture occurs on the same edge.
REQ-018 Capture with all 8 slots invalid: no output, FSM to/stays IDLE, no overflow count.
REQ-019 Presented slot = lowest-index set bit of pending; out_valid = |pending; outputs driven from registers only (no combinational path from any input to any output).
REQ-020 Latency: first cluster of a captured frame appears with out_valid=1 in the cycle immediately after the capture edge.
REQ-021 Handshake: out_valid & out_ready at an edge clears the presented slot's pending bit; the next lowest pending slot is presented the following cycle; one cluster per cycle maximum.
REQ-022 While out_valid=1 and out_ready=0, out_adr/out_cnt/out_sof/out_eof remain stable.
REQ-023 out_sof=1 from capture until the first handshake of that frame; out_eof=1 when exactly one pending bit remains.
REQ-024 out_adr/out_cnt/out_sof/out_eof are 0 whenever out_valid=0.
REQ-025 Capture during SEND: new frame overwrites buffer and pending mask unconditionally (capture wins); undelivered clusters of old frame are dropped; overflow_cnt increments by 1.
REQ-026 Exception to REQ-025: if the same edge handshakes the last pending cluster, no overflow is counted.
REQ-027 overflow_cnt saturates at 2^OVF_W-1 and never wraps.
REQ-028 out_ready is ignored when out_valid=0.

Reset
REQ-029 reset_n=0 asynchronously forces: FSM IDLE, pending=0, slot buffer=0, out_valid=0, out_adr=0, out_cnt=0, out_sof=0, out_eof=0, busy=0, overflow_cnt=0.
REQ-030 Reset asserted mid-frame drops all pending clusters without incrementing overflow_cnt; first capture after release behaves per REQ-016.
REQ-031 clusters_valid is ignored while reset_n=0.

Verification
REQ-032 Capture adr={5,2047,100,2047x5}, cnt={1,0,3,0..}, out_ready=1 -> next cycle adr 5 cnt 1 sof=1 eof=0, following cycle adr 100 cnt 3 sof=0 eof=1, then out_valid=0, busy=0.
REQ-033 Capture 8 valid clusters, out_ready=0 for 10 cycles then 1 -> slot 0 held stable 10 cycles, then slots 0..7 on 8 consecutive cycles, eof only on slot 7.
REQ-034 Capture 8 valid, accept 3, capture new frame -> overflow_cnt=1, next presented is new frame slot 0 with sof=1.
REQ-035 Capture new frame on same edge as handshake of old frame's last cluster -> overflow_cnt unchanged, new frame slot 0 presented next cycle.
REQ-036 300 overlapping captures with out_ready=0 -> overflow_cnt=255 held; capture of all adr=2047 -> out_valid stays 0.
REQ-037 Assert reset_n=0 mid-delivery -> all outputs 0 immediately (asynchronous), overflow_cnt=0 after release.
